// File: rtl/mpu_reg_seq.sv
// MPU-6050 register-level sequencer: turns one write/burst-read request into the byte
// sequence for the downstream I2C master FSM, pacing every step from that FSM's busy edges.
module mpu_reg_seq #(
    parameter logic [6:0] SLV_ADDR = 7'h68,
    parameter int         MAX_LEN  = 14,
    parameter int         TO_CYC   = 100000
) (
    input  logic       CLK,
    input  logic       RST_n,
    input  logic       I_START,
    input  logic       I_RW_REQ,
    input  logic [7:0] I_REG,
    input  logic [7:0] I_WDATA,
    input  logic [3:0] I_LEN,
    input  logic       I_BUSY,
    input  logic [7:0] I_DATA_RD,
    input  logic       I_ACK_FL,
    output logic       O_EN,
    output logic [6:0] O_ADDR,
    output logic       O_RW,
    output logic [7:0] O_DATA_WR,
    output logic [7:0] O_RD_DATA,
    output logic       O_RD_VLD,
    output logic [3:0] O_RD_IDX,
    output logic       O_READY,
    output logic       O_DONE,
    output logic       O_ERR
);

    localparam int              TW    = $clog2(TO_CYC + 1);
    localparam logic [TW-1:0]   TO_M1 = TW'(TO_CYC - 1);
    localparam logic [3:0]      MAX_L = 4'(MAX_LEN);

    typedef enum logic [2:0] {IDLE, LAUNCH, PTR, WDAT, RSTRT, RBYTE, RNEXT, FIN} st_t;

    st_t           st;
    logic          bsy_q;
    logic          rise;
    logic          fall;
    logic          timeout;
    logic [TW-1:0] timer;
    logic          rw_q;
    logic [7:0]    wdata_q;
    logic [3:0]    len_q;
    logic [3:0]    idx_q;

    function automatic logic [3:0] clamp_len(input logic [3:0] l);
        if (l == 4'd0) return 4'd1;
        if (l > MAX_L) return MAX_L;
        return l;
    endfunction

    assign O_ADDR  = SLV_ADDR;
    assign rise    = I_BUSY & ~bsy_q;
    assign fall    = ~I_BUSY & bsy_q;
    assign timeout = (timer == TO_M1) && !rise && !fall;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            st        <= IDLE;
            bsy_q     <= 1'b0;
            timer     <= '0;
            rw_q      <= 1'b0;
            wdata_q   <= 8'h00;
            len_q     <= 4'd1;
            idx_q     <= 4'd0;
            O_EN      <= 1'b0;
            O_RW      <= 1'b0;
            O_DATA_WR <= 8'h00;
            O_RD_DATA <= 8'h00;
            O_RD_VLD  <= 1'b0;
            O_RD_IDX  <= 4'd0;
            O_READY   <= 1'b1;
            O_DONE    <= 1'b0;
            O_ERR     <= 1'b0;
        end else begin
            bsy_q    <= I_BUSY;
            O_RD_VLD <= 1'b0;
            if (st == IDLE || rise || fall)
                timer <= '0;
            else
                timer <= timer + TW'(1);

            case (st)
                IDLE: begin
                    if (I_START && O_READY) begin
                        rw_q      <= I_RW_REQ;
                        wdata_q   <= I_WDATA;
                        len_q     <= clamp_len(I_LEN);
                        O_EN      <= 1'b1;
                        O_RW      <= 1'b0;
                        O_DATA_WR <= I_REG;
                        O_READY   <= 1'b0;
                        st        <= LAUNCH;
                    end
                end
                // A read completion enters FIN with DONE still low so DONE follows the last strobe
                FIN: begin
                    O_EN <= 1'b0;
                    if (!O_DONE) begin
                        O_DONE <= 1'b1;
                    end else begin
                        O_DONE  <= 1'b0;
                        O_ERR   <= 1'b0;
                        O_READY <= 1'b1;
                        st      <= IDLE;
                    end
                end
                default: begin
                    if ((fall && I_ACK_FL) || timeout) begin
                        O_EN   <= 1'b0;
                        O_DONE <= 1'b1;
                        O_ERR  <= 1'b1;
                        st     <= FIN;
                    end else begin
                        case (st)
                            LAUNCH: if (rise) begin
                                if (rw_q) O_RW <= 1'b1;
                                else      O_DATA_WR <= wdata_q;
                                st <= PTR;
                            end
                            PTR: if (fall) begin
                                if (rw_q) begin
                                    st <= RSTRT;
                                end else begin
                                    O_EN <= 1'b0;
                                    st   <= WDAT;
                                end
                            end
                            WDAT: if (fall) begin
                                O_DONE <= 1'b1;
                                st     <= FIN;
                            end
                            RSTRT: if (rise) begin
                                O_EN  <= (len_q > 4'd1);
                                idx_q <= 4'd0;
                                st    <= RBYTE;
                            end
                            // Dropping EN one byte early makes the master NACK the final byte
                            RBYTE: if (fall) begin
                                O_RD_DATA <= I_DATA_RD;
                                O_RD_VLD  <= 1'b1;
                                O_RD_IDX  <= idx_q;
                                if (idx_q == len_q - 4'd1) begin
                                    st <= FIN;
                                end else begin
                                    idx_q <= idx_q + 4'd1;
                                    if (idx_q + 4'd1 == len_q - 4'd1) O_EN <= 1'b0;
                                    st <= RNEXT;
                                end
                            end
                            RNEXT: if (rise) st <= RBYTE;
                            default: st <= IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule
